// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU front end: FSM encoding, port ids and default widths.
package alu_ctrl_pkg;

    localparam int unsigned ALU_L = 16;
    localparam int unsigned ALU_P = 0;

    localparam logic PORT_EXEC = 1'b0;
    localparam logic PORT_ADDR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/ALU.sv
// Shared combinational ALU: op 0 = signed divide, op 1 = signed multiply.
// Flags: bit0 zero, bit1 negative, bit2 overflow, bit3 divide-by-zero; upper bits pass through.
module ALU #(
    parameter int unsigned L = 16,
    parameter int unsigned P = 0
) (
    input  logic signed [L-1:0] A,
    input  logic signed [L-1:0] B,
    input  logic        [P:0]   Operation,
    input  logic        [L-1:0] FlagsIn,
    output logic        [L-1:0] R,
    output logic        [L-1:0] FlagsOut
);

    localparam logic [L-1:0] MIN_VAL = {1'b1, {(L-1){1'b0}}};

    logic signed [2*L-1:0] prod;
    logic                  ovf;
    logic                  dz;

    assign prod = $signed({{L{A[L-1]}}, A}) * $signed({{L{B[L-1]}}, B});

    always_comb begin
        R   = '0;
        ovf = 1'b0;
        dz  = 1'b0;
        if (Operation[0]) begin
            R   = prod[L-1:0];
            ovf = prod[2*L-1:L] != {L{prod[L-1]}};
        end else if (B == '0) begin
            dz = 1'b1;
        end else if (A == MIN_VAL && B == '1) begin
            // Only quotient that does not fit: wraps back to the minimum value
            R   = A;
            ovf = 1'b1;
        end else begin
            R = A / B;
        end
        FlagsOut    = FlagsIn;
        FlagsOut[0] = (R == '0);
        FlagsOut[1] = R[L-1];
        FlagsOut[2] = ovf;
        FlagsOut[3] = dz;
    end

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a tie goes to the port that was not granted last.
module rr_arbiter2
    import alu_ctrl_pkg::*;
(
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       last_grant_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    logic pick1;

    assign pick1 = valid1_i & (~valid0_i | (last_grant_i == PORT_EXEC));

    always_comb begin
        grant_o = 2'b00;
        if (accept_i) begin
            grant_o = pick1 ? 2'b10 : {1'b0, valid0_i};
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Sequential front end for the shared ALU: arbitrates two requesters, registers operands
// and results, returns results over valid/ready and owns the committed flags register.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned L = ALU_L,
    parameter int unsigned P = ALU_P
) (
    input  logic                Clock,
    input  logic                ResetN,
    input  logic                Valid0,
    input  logic                Valid1,
    output logic                Ready0,
    output logic                Ready1,
    input  logic        [P:0]   Op0,
    input  logic        [P:0]   Op1,
    input  logic signed [L-1:0] A0,
    input  logic signed [L-1:0] B0,
    input  logic signed [L-1:0] A1,
    input  logic signed [L-1:0] B1,
    output logic                RespValid,
    input  logic                RespReady,
    output logic                RespId,
    output logic        [L-1:0] R,
    output logic        [L-1:0] FlagsOut,
    output logic        [L-1:0] Flags,
    input  logic                FlagsLoad,
    input  logic        [L-1:0] FlagsData,
    output logic                Busy
);

    state_e              state_q;
    logic                last_grant_q;
    logic                id_q;
    logic        [P:0]   op_q;
    logic signed [L-1:0] a_q;
    logic signed [L-1:0] b_q;
    logic        [L-1:0] r_q;
    logic        [L-1:0] flags_out_q;
    logic        [L-1:0] flags_q;
    logic        [L-1:0] flags_d;
    logic                resp_id_q;
    logic                resp_valid_q;
    logic                busy_q;

    logic                accept;
    logic        [1:0]   gnt;
    logic                grant_id;
    logic        [L-1:0] alu_r;
    logic        [L-1:0] alu_flags;

    // A new request can enter from IDLE, or from RESP in the cycle the result is taken
    assign accept = ResetN & (Valid0 | Valid1)
                  & ((state_q == ST_IDLE) | ((state_q == ST_RESP) & RespReady));

    rr_arbiter2 u_arb (
        .valid0_i     (Valid0),
        .valid1_i     (Valid1),
        .last_grant_i (last_grant_q),
        .accept_i     (accept),
        .grant_o      (gnt)
    );

    assign grant_id = gnt[1];

    ALU #(.L(L), .P(P)) u_alu (
        .A         (a_q),
        .B         (b_q),
        .Operation (op_q),
        .FlagsIn   (flags_q),
        .R         (alu_r),
        .FlagsOut  (alu_flags)
    );

    // Context-restore loads only in IDLE; otherwise flags move only on a response handshake
    always_comb begin
        flags_d = flags_q;
        if (state_q == ST_IDLE && FlagsLoad) begin
            flags_d = FlagsData;
        end else if (state_q == ST_RESP && RespReady) begin
            flags_d = flags_out_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_ADDR;
            id_q         <= PORT_EXEC;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            r_q          <= '0;
            flags_out_q  <= '0;
            flags_q      <= '0;
            resp_id_q    <= PORT_EXEC;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            flags_q <= flags_d;
            if (accept) begin
                op_q         <= grant_id ? Op1 : Op0;
                a_q          <= grant_id ? A1 : A0;
                b_q          <= grant_id ? B1 : B0;
                id_q         <= grant_id;
                last_grant_q <= grant_id;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_EXEC;
                        busy_q  <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    r_q          <= alu_r;
                    flags_out_q  <= alu_flags;
                    resp_id_q    <= id_q;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (RespReady) begin
                        resp_valid_q <= 1'b0;
                        if (accept) begin
                            state_q <= ST_EXEC;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign Ready0    = gnt[0];
    assign Ready1    = gnt[1];
    assign RespValid = resp_valid_q;
    assign RespId    = resp_id_q;
    assign R         = r_q;
    assign FlagsOut  = flags_out_q;
    assign Flags     = flags_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a transaction-level model is checked every cycle,
// with hand-computed literal expectations at key points.
module tb_alu_arbiter;

    logic               Clock;
    logic               ResetN;
    logic               Valid0, Valid1;
    logic               Ready0, Ready1;
    logic        [0:0]  Op0, Op1;
    logic signed [15:0] A0, B0, A1, B1;
    logic               RespValid, RespReady, RespId;
    logic        [15:0] R, FlagsOut, Flags;
    logic               FlagsLoad;
    logic        [15:0] FlagsData;
    logic               Busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter #(.L(16), .P(0)) dut (
        .Clock     (Clock),
        .ResetN    (ResetN),
        .Valid0    (Valid0),
        .Valid1    (Valid1),
        .Ready0    (Ready0),
        .Ready1    (Ready1),
        .Op0       (Op0),
        .Op1       (Op1),
        .A0        (A0),
        .B0        (B0),
        .A1        (A1),
        .B1        (B1),
        .RespValid (RespValid),
        .RespReady (RespReady),
        .RespId    (RespId),
        .R         (R),
        .FlagsOut  (FlagsOut),
        .Flags     (Flags),
        .FlagsLoad (FlagsLoad),
        .FlagsData (FlagsData),
        .Busy      (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic meaning of the ALU: exact result in wide integers, then truncated.
    function automatic logic [31:0] model_alu(input logic op, input logic signed [15:0] a,
                                              input logic signed [15:0] b, input logic [15:0] fin);
        longint la, lb, res;
        logic   v, dz;
        logic [15:0] r;
        la = a;
        lb = b;
        dz = 1'b0;
        if (op) res = la * lb;
        else if (lb == 0) begin res = 0; dz = 1'b1; end
        else res = la / lb;
        v = (res > 32767) || (res < -32768);
        r = res[15:0];
        return {r, fin[15:4], dz, v, r[15], (r == 16'h0000)};
    endfunction

    // Transaction model: one op in flight (computing) or one result held, never both.
    logic        m_ok = 1'b0;
    logic        m_pend, m_rv, m_last, m_id, m_rid, m_op;
    logic [15:0] m_a, m_b, m_r, m_fo, m_fl;

    always @(negedge Clock) begin
        logic        acc, gid;
        logic [31:0] res;
        acc = ResetN && (Valid0 || Valid1) && !m_pend && (!m_rv || RespReady);
        gid = (Valid0 && Valid1) ? !m_last : Valid1;
        if (m_ok) begin
            chk("cyc_ready0", 32'(Ready0), 32'(acc && !gid));
            chk("cyc_ready1", 32'(Ready1), 32'(acc && gid));
            chk("cyc_respvalid", 32'(RespValid), 32'(m_rv));
            chk("cyc_busy", 32'(Busy), 32'(m_pend || m_rv));
            chk("cyc_r", 32'(R), 32'(m_r));
            chk("cyc_flagsout", 32'(FlagsOut), 32'(m_fo));
            chk("cyc_respid", 32'(RespId), 32'(m_rid));
            chk("cyc_flags", 32'(Flags), 32'(m_fl));
        end
        if (!ResetN) begin
            m_ok = 1'b1; m_pend = 1'b0; m_rv = 1'b0; m_last = 1'b1; m_id = 1'b0;
            m_rid = 1'b0; m_r = '0; m_fo = '0; m_fl = '0; m_op = 1'b0; m_a = '0; m_b = '0;
        end else if (m_ok) begin
            if (m_rv && RespReady) begin
                m_fl = m_fo;
                m_rv = 1'b0;
            end else if (!m_pend && !m_rv && FlagsLoad) begin
                m_fl = FlagsData;
            end
            if (m_pend) begin
                res   = model_alu(m_op, m_a, m_b, m_fl);
                m_r   = res[31:16];
                m_fo  = res[15:0];
                m_rid = m_id;
                m_rv  = 1'b1;
                m_pend = 1'b0;
            end
            if (acc) begin
                m_pend = 1'b1;
                m_id   = gid;
                m_last = gid;
                m_op   = gid ? Op1[0] : Op0[0];
                m_a    = gid ? A1 : A0;
                m_b    = gid ? B1 : B0;
            end
        end
    end

    // Advance one cycle; a requester drops Valid once its Ready was seen.
    task automatic tick();
        logic r0, r1;
        @(negedge Clock);
        r0 = Ready0;
        r1 = Ready1;
        @(posedge Clock);
        #1;
        if (r0) Valid0 = 1'b0;
        if (r1) Valid1 = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        Valid0 = 1'b0; Valid1 = 1'b0; FlagsLoad = 1'b0;
        ResetN = 1'b0;
        tick();
        ResetN = 1'b1;
    endtask

    task automatic drain();
        Valid0 = 1'b0; Valid1 = 1'b0; RespReady = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!Busy) break;
            tick();
        end
        chk("drain_idle", 32'(Busy), 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int g[$];
        ResetN = 1'b0; Valid0 = 1'b0; Valid1 = 1'b0; Op0 = '0; Op1 = '0;
        A0 = '0; B0 = '0; A1 = '0; B1 = '0; RespReady = 1'b0; FlagsLoad = 1'b0; FlagsData = '0;
        tick();
        tick();
        chk("rst_flags", 32'(Flags), 32'd0);
        chk("rst_respvalid", 32'(RespValid), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_r", 32'(R), 32'd0);
        ResetN = 1'b1;

        // Single request: 2 * 3
        Valid0 = 1'b1; Op0 = 1'b1; A0 = 16'sd2; B0 = 16'sd3;
        settle();
        chk("t1_ready0", 32'(Ready0), 32'd1);
        tick();
        tick();
        chk("t1_respvalid", 32'(RespValid), 32'd1);
        chk("t1_r", 32'(R), 32'd6);
        chk("t1_id", 32'(RespId), 32'd0);
        RespReady = 1'b1;
        tick();
        chk("t1_flags", 32'(Flags), 32'h0000);
        chk("t1_idle", 32'(RespValid), 32'd0);
        RespReady = 1'b0;

        // Simultaneous requests, then continuous ties alternate
        do_reset();
        Valid0 = 1'b1; Op0 = 1'b0; A0 = 16'sd6; B0 = 16'sd3;
        Valid1 = 1'b1; Op1 = 1'b1; A1 = 16'sd6; B1 = 16'sd6;
        RespReady = 1'b1;
        settle();
        chk("t2_ready0", 32'(Ready0), 32'd1);
        chk("t2_ready1_low", 32'(Ready1), 32'd0);
        tick();
        tick();
        chk("t2_r0", 32'(R), 32'd2);
        chk("t2_id0", 32'(RespId), 32'd0);
        settle();
        chk("t2_ready1", 32'(Ready1), 32'd1);
        tick();
        tick();
        chk("t2_r1", 32'(R), 32'd36);
        chk("t2_id1", 32'(RespId), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (!Valid0) begin Valid0 = 1'b1; Op0 = i[0]; A0 = 16'(i + 1); B0 = 16'sd3; end
            if (!Valid1) begin Valid1 = 1'b1; Op1 = ~i[0]; A1 = 16'(-(i + 2)); B1 = 16'(i + 5); end
            settle();
            if (Ready0) g.push_back(0);
            else if (Ready1) g.push_back(1);
            tick();
        end
        chk("fair_count", 32'(g.size()), 32'd4);
        for (int k = 0; k < g.size(); k++) chk("fair_order", 32'(g[k]), 32'(k % 2));
        drain();

        // Backpressure with port 1 waiting
        do_reset();
        RespReady = 1'b0;
        Valid0 = 1'b1; Op0 = 1'b1; A0 = 16'(-3); B0 = 16'sd5;
        tick();
        Valid1 = 1'b1; Op1 = 1'b0; A1 = 16'sd100; B1 = 16'sd7;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_respvalid", 32'(RespValid), 32'd1);
            chk("bp_r", 32'(R), 32'h0000FFF1);
            chk("bp_id", 32'(RespId), 32'd0);
            chk("bp_ready1", 32'(Ready1), 32'd0);
            chk("bp_flags", 32'(Flags), 32'h0000);
            tick();
        end
        RespReady = 1'b1;
        settle();
        chk("bp_release_ready1", 32'(Ready1), 32'd1);
        tick();
        chk("bp_flags_commit", 32'(Flags), 32'h0002);
        chk("bp_busy_exec", 32'(Busy), 32'd1);
        tick();
        chk("bp_r2", 32'(R), 32'd14);
        chk("bp_id2", 32'(RespId), 32'd1);
        tick();
        chk("bp_flags2", 32'(Flags), 32'h0000);

        // Flags load: honoured in IDLE, ignored in EXEC/RESP, combined with accept
        FlagsLoad = 1'b1; FlagsData = 16'h00A5;
        tick();
        FlagsLoad = 1'b0;
        chk("fl_load", 32'(Flags), 32'h00A5);
        RespReady = 1'b0;
        Valid0 = 1'b1; Op0 = 1'b1; A0 = 16'sd1; B0 = 16'sd1;
        tick();
        FlagsLoad = 1'b1; FlagsData = 16'h1234;
        tick();
        tick();
        chk("fl_ignored", 32'(Flags), 32'h00A5);
        chk("fl_r", 32'(R), 32'd1);
        chk("fl_flagsout", 32'(FlagsOut), 32'h00A0);
        FlagsLoad = 1'b0;
        RespReady = 1'b1;
        tick();
        chk("fl_commit", 32'(Flags), 32'h00A0);
        FlagsLoad = 1'b1; FlagsData = 16'h0F30;
        Valid1 = 1'b1; Op1 = 1'b1; A1 = 16'sd2; B1 = 16'hFFFF;
        tick();
        FlagsLoad = 1'b0;
        chk("fl_load_accept", 32'(Flags), 32'h0F30);
        tick();
        chk("fl_acc_r", 32'(R), 32'h0000FFFE);
        chk("fl_acc_flagsout", 32'(FlagsOut), 32'h0F32);
        tick();
        chk("fl_acc_commit", 32'(Flags), 32'h0F32);

        // Reset during EXEC drops the operation
        RespReady = 1'b0;
        Valid0 = 1'b1; Op0 = 1'b0; A0 = 16'sd9; B0 = 16'sd3;
        tick();
        ResetN = 1'b0;
        tick();
        ResetN = 1'b1;
        chk("mr_respvalid", 32'(RespValid), 32'd0);
        chk("mr_busy", 32'(Busy), 32'd0);
        chk("mr_flags", 32'(Flags), 32'h0000);
        chk("mr_r", 32'(R), 32'h0000);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mr_no_resp", 32'(RespValid), 32'd0);
        end

        // Division corners
        FlagsLoad = 1'b1; FlagsData = 16'hFF00;
        tick();
        FlagsLoad = 1'b0;
        Valid0 = 1'b1; Op0 = 1'b0; A0 = 16'(-16); B0 = 16'hFFFF;
        tick();
        tick();
        chk("dv_r", 32'(R), 32'h0010);
        chk("dv_flagsout", 32'(FlagsOut), 32'hFF00);
        RespReady = 1'b1;
        tick();
        chk("dv_commit", 32'(Flags), 32'hFF00);
        RespReady = 1'b0;
        Valid0 = 1'b1; Op0 = 1'b0; A0 = 16'sd6; B0 = 16'sd0;
        tick();
        tick();
        chk("dz_r", 32'(R), 32'h0000);
        chk("dz_flagsout", 32'(FlagsOut), 32'hFF09);
        chk("dz_flags_held", 32'(Flags), 32'hFF00);
        RespReady = 1'b1;
        tick();
        chk("dz_commit", 32'(Flags), 32'hFF09);
        RespReady = 1'b0;
        Valid0 = 1'b1; Op0 = 1'b0; A0 = 16'h8000; B0 = 16'hFFFF;
        tick();
        tick();
        chk("ov_r", 32'(R), 32'h8000);
        chk("ov_flagsout", 32'(FlagsOut), 32'hFF06);
        RespReady = 1'b1;
        tick();
        chk("ov_commit", 32'(Flags), 32'hFF06);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
